// File: rtl/vga_pkg.sv
// Shared VGA timing descriptor type and a couple of standard mode tables.
package vga_pkg;

    localparam int unsigned VGA_CNT_W = 16;

    typedef struct packed {
        logic [VGA_CNT_W-1:0] act;
        logic [VGA_CNT_W-1:0] fp;
        logic [VGA_CNT_W-1:0] sync;
        logic [VGA_CNT_W-1:0] bp;
    } vga_timing_t;

    localparam vga_timing_t VGA_720x400_H = '{act: 16'd720, fp: 16'd18, sync: 16'd108, bp: 16'd54};
    localparam vga_timing_t VGA_720x400_V = '{act: 16'd400, fp: 16'd12, sync: 16'd2,   bp: 16'd35};
    localparam vga_timing_t VGA_640x480_H = '{act: 16'd640, fp: 16'd16, sync: 16'd96,  bp: 16'd48};
    localparam vga_timing_t VGA_640x480_V = '{act: 16'd480, fp: 16'd10, sync: 16'd2,   bp: 16'd33};

endpackage

// File: rtl/vga_axis_cnt.sv
// One timing axis: wrapping position counter with registered sync/active/coordinate decode.
// Region order along the axis is sync, back porch, active, front porch.
module vga_axis_cnt #(
    parameter int unsigned CNT_W = 16,
    parameter int unsigned ACT   = 720,
    parameter int unsigned FP    = 18,
    parameter int unsigned SYNC  = 108,
    parameter int unsigned BP    = 54,
    parameter bit          POL   = 1'b0
) (
    input  logic             clock,
    input  logic             rst_i,
    input  logic             i_en,
    output logic             o_wrap,
    output logic             o_last_nxt,
    output logic             o_active_nxt,
    output logic             o_sync,
    output logic             o_active,
    output logic [CNT_W-1:0] o_coord
);

    localparam logic [CNT_W-1:0] SYNC_END = CNT_W'(SYNC);
    localparam logic [CNT_W-1:0] START    = CNT_W'(SYNC + BP);
    localparam logic [CNT_W-1:0] STOP     = CNT_W'(SYNC + BP + ACT);
    localparam logic [CNT_W-1:0] LAST     = CNT_W'(SYNC + BP + ACT + FP - 1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_sync_nxt;
    logic             r_sync;
    logic             r_active;
    logic [CNT_W-1:0] r_coord;

    assign o_wrap = (r_cnt == LAST);

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (i_en) begin
            w_cnt_nxt = o_wrap ? '0 : r_cnt + CNT_W'(1);
        end
    end

    // Decoding the next count keeps the registered outputs aligned with the counter.
    assign w_sync_nxt   = (w_cnt_nxt < SYNC_END);
    assign o_active_nxt = (w_cnt_nxt >= START) && (w_cnt_nxt < STOP);
    assign o_last_nxt   = (w_cnt_nxt == LAST);

    always_ff @(posedge clock) begin
        if (rst_i) begin
            r_cnt    <= '0;
            r_sync   <= POL;
            r_active <= 1'b0;
            r_coord  <= '0;
        end else begin
            r_cnt    <= w_cnt_nxt;
            r_sync   <= w_sync_nxt ? POL : ~POL;
            r_active <= o_active_nxt;
            r_coord  <= o_active_nxt ? (w_cnt_nxt - START) : '0;
        end
    end

    assign o_sync   = r_sync;
    assign o_active = r_active;
    assign o_coord  = r_coord;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator with pixel clock enable and linear pixel address.
// Defining VGA_TIMING_FRAME_CNT_EN adds the 16-bit frame counter output frame_o.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_ACT  = 32'(VGA_720x400_H.act),
    parameter int unsigned H_FP   = 32'(VGA_720x400_H.fp),
    parameter int unsigned H_SYNC = 32'(VGA_720x400_H.sync),
    parameter int unsigned H_BP   = 32'(VGA_720x400_H.bp),
    parameter int unsigned V_ACT  = 32'(VGA_720x400_V.act),
    parameter int unsigned V_FP   = 32'(VGA_720x400_V.fp),
    parameter int unsigned V_SYNC = 32'(VGA_720x400_V.sync),
    parameter int unsigned V_BP   = 32'(VGA_720x400_V.bp),
    parameter bit          H_POL  = 1'b0,
    parameter bit          V_POL  = 1'b1,
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned ADDR_W = 19
) (
    input  logic              clock,
    input  logic              rst_i,
    input  logic              pix_ce_i,
    output logic              hs,
    output logic              vs,
    output logic              h_active,
    output logic              v_active,
    output logic              de,
    output logic              eol,
    output logic              eos,
    output logic [CNT_W-1:0]  x,
    output logic [CNT_W-1:0]  y,
    output logic [ADDR_W-1:0] pixel
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    output logic [15:0]       frame_o
`endif
);

    localparam longint unsigned H_TOTAL = 64'(H_SYNC) + 64'(H_BP) + 64'(H_ACT) + 64'(H_FP);
    localparam longint unsigned V_TOTAL = 64'(V_SYNC) + 64'(V_BP) + 64'(V_ACT) + 64'(V_FP);

    if (H_ACT < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 || V_ACT < 1 || V_FP < 1 ||
        V_SYNC < 1 || V_BP < 1 || CNT_W < 1 || ADDR_W < 1) begin : g_bad_zero
        $fatal(1, "vga_timing_gen: every size parameter must be at least 1");
    end
    if (H_TOTAL >= (64'd1 << CNT_W) || V_TOTAL >= (64'd1 << CNT_W)) begin : g_bad_cnt_w
        $fatal(1, "vga_timing_gen: CNT_W too narrow for the line/frame totals");
    end
    if (64'(H_ACT) * 64'(V_ACT) > (64'd1 << ADDR_W)) begin : g_bad_addr_w
        $fatal(1, "vga_timing_gen: ADDR_W too narrow for the active area");
    end

    logic              w_h_wrap;
    logic              w_h_last_nxt;
    logic              w_h_act_nxt;
    logic              w_v_en;
    logic              w_v_wrap_unused;
    logic              w_v_last_nxt;
    logic              w_v_act_nxt;
    logic              r_de;
    logic              r_eol;
    logic              r_eos;
    logic [ADDR_W-1:0] r_pixel;

    vga_axis_cnt #(
        .CNT_W (CNT_W),
        .ACT   (H_ACT),
        .FP    (H_FP),
        .SYNC  (H_SYNC),
        .BP    (H_BP),
        .POL   (H_POL)
    ) u_h_axis (
        .clock        (clock),
        .rst_i        (rst_i),
        .i_en         (pix_ce_i),
        .o_wrap       (w_h_wrap),
        .o_last_nxt   (w_h_last_nxt),
        .o_active_nxt (w_h_act_nxt),
        .o_sync       (hs),
        .o_active     (h_active),
        .o_coord      (x)
    );

    assign w_v_en = w_h_wrap & pix_ce_i;

    vga_axis_cnt #(
        .CNT_W (CNT_W),
        .ACT   (V_ACT),
        .FP    (V_FP),
        .SYNC  (V_SYNC),
        .BP    (V_BP),
        .POL   (V_POL)
    ) u_v_axis (
        .clock        (clock),
        .rst_i        (rst_i),
        .i_en         (w_v_en),
        .o_wrap       (w_v_wrap_unused),
        .o_last_nxt   (w_v_last_nxt),
        .o_active_nxt (w_v_act_nxt),
        .o_sync       (vs),
        .o_active     (v_active),
        .o_coord      (y)
    );

    always_ff @(posedge clock) begin
        if (rst_i) begin
            r_de    <= 1'b0;
            r_eol   <= 1'b0;
            r_eos   <= 1'b0;
            r_pixel <= '0;
        end else if (pix_ce_i) begin
            r_de  <= w_h_act_nxt & w_v_act_nxt;
            r_eol <= w_h_last_nxt;
            r_eos <= w_h_last_nxt & w_v_last_nxt;
            // Address counts pixels already shown; the frame boundary restarts it.
            if (r_eos) begin
                r_pixel <= '0;
            end else if (r_de) begin
                r_pixel <= r_pixel + ADDR_W'(1);
            end
        end
    end

    assign de    = r_de;
    assign eol   = r_eol;
    assign eos   = r_eos;
    assign pixel = r_pixel;

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] r_frame;

    always_ff @(posedge clock) begin
        if (rst_i) begin
            r_frame <= '0;
        end else if (pix_ce_i && r_eos) begin
            r_frame <= r_frame + 16'd1;
        end
    end

    assign frame_o = r_frame;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: small-mode vector table, clock-enable toggling, default-mode
// line/active-window sequence and mid-frame reset.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default (720x400) instance
    logic        b_rst, b_ce, b_hs, b_vs, b_ha, b_va, b_de, b_eol, b_eos;
    logic [15:0] b_x, b_y;
    logic [18:0] b_pix;
    // Small 4/1/1/1 x 3/1/1/1 instance
    logic        s_rst, s_ce, s_hs, s_vs, s_ha, s_va, s_de, s_eol, s_eos;
    logic [7:0]  s_x, s_y;
    logic [3:0]  s_pix;
`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] b_frame, s_frame;
`endif

    vga_timing_gen u_big (
        .clock    (clk),
        .rst_i    (b_rst),
        .pix_ce_i (b_ce),
        .hs       (b_hs),
        .vs       (b_vs),
        .h_active (b_ha),
        .v_active (b_va),
        .de       (b_de),
        .eol      (b_eol),
        .eos      (b_eos),
        .x        (b_x),
        .y        (b_y),
        .pixel    (b_pix)
`ifdef VGA_TIMING_FRAME_CNT_EN
        ,
        .frame_o  (b_frame)
`endif
    );

    vga_timing_gen #(
        .H_ACT (4), .H_FP (1), .H_SYNC (1), .H_BP (1),
        .V_ACT (3), .V_FP (1), .V_SYNC (1), .V_BP (1),
        .H_POL (1'b1), .V_POL (1'b0), .CNT_W (8), .ADDR_W (4)
    ) u_small (
        .clock    (clk),
        .rst_i    (s_rst),
        .pix_ce_i (s_ce),
        .hs       (s_hs),
        .vs       (s_vs),
        .h_active (s_ha),
        .v_active (s_va),
        .de       (s_de),
        .eol      (s_eol),
        .eos      (s_eos),
        .x        (s_x),
        .y        (s_y),
        .pixel    (s_pix)
`ifdef VGA_TIMING_FRAME_CNT_EN
        ,
        .frame_o  (s_frame)
`endif
    );

    typedef struct {
        int         k;      // pix_ce steps since reset
        logic [6:0] flags;  // {hs, vs, h_active, v_active, de, eol, eos}
        int         x;
        int         y;
        int         pix;
    } vec_t;

    vec_t vecs [16];

    int checks;
    int errors;
    int k;
    int unstable, eol_rise, eol_clk, eol_t1, eol_t2, eol_run, eol_max_run;
    int eos_rise, eos_t1, eos_t2, de_clk, hs_clk, max_pix;
    int eol1, eol2, eol3, hs_low, vs_fall, de1, de1_x, de1_y, de1_pix;
    logic [26:0] prev_v, cur_v;
    logic        prev_eol, prev_eos;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [6:0] s_flags();
        return {s_hs, s_vs, s_ha, s_va, s_de, s_eol, s_eos};
    endfunction

    function automatic logic [6:0] b_flags();
        return {b_hs, b_vs, b_ha, b_va, b_de, b_eol, b_eos};
    endfunction

    initial begin
        checks = 0;
        errors = 0;
        b_rst  = 1'b1;
        b_ce   = 1'b0;
        s_rst  = 1'b1;
        s_ce   = 1'b0;

        vecs[0]  = '{0,  7'b1000000, 0, 0, 0};
        vecs[1]  = '{1,  7'b0000000, 0, 0, 0};
        vecs[2]  = '{6,  7'b0000010, 0, 0, 0};
        vecs[3]  = '{7,  7'b1100000, 0, 0, 0};
        vecs[4]  = '{16, 7'b0111100, 0, 0, 0};
        vecs[5]  = '{17, 7'b0111100, 1, 0, 1};
        vecs[6]  = '{19, 7'b0111100, 3, 0, 3};
        vecs[7]  = '{20, 7'b0101010, 0, 0, 4};
        vecs[8]  = '{23, 7'b0111100, 0, 1, 4};
        vecs[9]  = '{32, 7'b0111100, 2, 2, 10};
        vecs[10] = '{33, 7'b0111100, 3, 2, 11};
        vecs[11] = '{34, 7'b0101010, 0, 2, 12};
        vecs[12] = '{35, 7'b1100000, 0, 0, 12};
        vecs[13] = '{41, 7'b0100011, 0, 0, 12};
        vecs[14] = '{42, 7'b1000000, 0, 0, 0};
        vecs[15] = '{58, 7'b0111100, 0, 0, 0};

        // Small mode, pix_ce held high: table walk through one frame and into the next
        tick();
        s_rst = 1'b0;
        s_ce  = 1'b1;
        k     = 0;
        for (int i = 0; i < 16; i++) begin
            while (k < vecs[i].k) begin
                tick();
                k++;
            end
            check($sformatf("vec%0d_k%0d_flags", i, vecs[i].k), s_flags(), vecs[i].flags);
            check($sformatf("vec%0d_k%0d_x", i, vecs[i].k), s_x, vecs[i].x);
            check($sformatf("vec%0d_k%0d_y", i, vecs[i].k), s_y, vecs[i].y);
            check($sformatf("vec%0d_k%0d_pixel", i, vecs[i].k), s_pix, vecs[i].pix);
        end

        // Small mode, pix_ce toggling 1/0: three frames
        s_rst = 1'b1;
        s_ce  = 1'b0;
        tick();
        s_rst = 1'b0;
        unstable = 0; eol_rise = 0; eol_clk = 0; eol_t1 = -1; eol_t2 = -1;
        eol_run = 0; eol_max_run = 0; eos_rise = 0; eos_t1 = -1; eos_t2 = -1;
        de_clk = 0; hs_clk = 0; max_pix = 0;
        prev_v   = {s_flags(), s_x, s_y, s_pix};
        prev_eol = s_eol;
        prev_eos = s_eos;
        for (int t = 0; t < 256; t++) begin
            s_ce = (t % 2 == 0);
            tick();
            cur_v = {s_flags(), s_x, s_y, s_pix};
            if (!s_ce && cur_v != prev_v) unstable++;
            if (s_eol) begin
                eol_clk++;
                eol_run++;
                if (eol_run > eol_max_run) eol_max_run = eol_run;
            end else begin
                eol_run = 0;
            end
            if (s_eol && !prev_eol) begin
                eol_rise++;
                if (eol_t1 < 0) eol_t1 = t;
                else if (eol_t2 < 0) eol_t2 = t;
            end
            if (s_eos && !prev_eos) begin
                eos_rise++;
                if (eos_t1 < 0) eos_t1 = t;
                else if (eos_t2 < 0) eos_t2 = t;
            end
            if (s_de) begin
                de_clk++;
                if (int'(s_pix) > max_pix) max_pix = int'(s_pix);
            end
            if (s_hs) hs_clk++;
            prev_v   = cur_v;
            prev_eol = s_eol;
            prev_eos = s_eos;
        end
        check("ce_hold_unstable", unstable, 0);
        check("ce_eol_rises", eol_rise, 18);
        check("ce_eol_clocks", eol_clk, 36);
        check("ce_eol_width", eol_max_run, 2);
        check("ce_eol_period", eol_t2 - eol_t1, 14);
        check("ce_eos_rises", eos_rise, 3);
        check("ce_eos_period", eos_t2 - eos_t1, 84);
        check("ce_de_clocks", de_clk, 72);
        check("ce_hs_clocks", hs_clk, 36);
        check("ce_max_pixel", max_pix, 11);
`ifdef VGA_TIMING_FRAME_CNT_EN
        check("frame_o_after_3", s_frame, 3);
`endif
        s_rst = 1'b1;
        s_ce  = 1'b0;

        // Default mode: reset state, line timing and the first active lines
        tick();
        check("big_reset_flags", b_flags(), 7'b0100000);
        check("big_reset_x", b_x, 0);
        check("big_reset_y", b_y, 0);
        check("big_reset_pixel", b_pix, 0);
        b_rst = 1'b0;
        b_ce  = 1'b1;
        eol1 = -1; eol2 = -1; hs_low = 0; vs_fall = -1; de1 = -1;
        de1_x = -1; de1_y = -1; de1_pix = -1;
        for (int kk = 1; kk <= 34362; kk++) begin
            tick();
            if (b_eol) begin
                if (eol1 < 0) eol1 = kk;
                else if (eol2 < 0) eol2 = kk;
            end
            if (kk >= 900 && kk < 1800 && !b_hs) hs_low++;
            if (!b_vs && vs_fall < 0) vs_fall = kk;
            if (b_de && de1 < 0) begin
                de1     = kk;
                de1_x   = int'(b_x);
                de1_y   = int'(b_y);
                de1_pix = int'(b_pix);
            end
            if (kk == 34181) begin
                check("big_line0_last_de", b_de, 1);
                check("big_line0_last_x", b_x, 719);
                check("big_line0_last_pixel", b_pix, 719);
            end
            if (kk == 34182) begin
                check("big_line0_fp_de", b_de, 0);
                check("big_line0_fp_pixel", b_pix, 720);
            end
            if (kk == 34362) begin
                check("big_line1_de", b_de, 1);
                check("big_line1_x", b_x, 0);
                check("big_line1_y", b_y, 1);
                check("big_line1_pixel", b_pix, 720);
            end
        end
        check("big_first_eol", eol1, 899);
        check("big_second_eol", eol2, 1799);
        check("big_hs_low_clocks", hs_low, 108);
        check("big_vs_fall", vs_fall, 1800);
        check("big_first_de", de1, 33462);
        check("big_first_de_x", de1_x, 0);
        check("big_first_de_y", de1_y, 0);
        check("big_first_de_pixel", de1_pix, 0);

        // Mid-frame reset with pix_ce low still takes effect
        b_rst = 1'b1;
        b_ce  = 1'b0;
        tick();
        check("big_midreset_flags", b_flags(), 7'b0100000);
        check("big_midreset_x", b_x, 0);
        check("big_midreset_y", b_y, 0);
        check("big_midreset_pixel", b_pix, 0);
        b_rst = 1'b0;
        b_ce  = 1'b1;
        eol3 = -1;
        for (int kk = 1; kk <= 1000; kk++) begin
            tick();
            if (b_eol && eol3 < 0) eol3 = kk;
        end
        check("big_midreset_eol", eol3, 899);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
